flow_seq_ctrl: RTL

Multi-cycle control-flow sequencer for the 5-stage pipeline. Owns the stack-push/pop and PC-redirect sequences for hardware interrupt entry, RET and RTI. Freezes fetch while a sequence runs and drives the step counter `seq_count` consumed by the hazard detection unit. Sits beside the HDU between decode and the memory/PC-select logic.

---
 rtl/flow_seq_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/flow_seq_ctrl.sv
// Control-flow sequencer: runs the stack push/pop and PC-redirect sequences
// for interrupt entry, RET and RTI while freezing fetch.
module flow_seq_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic       ret_dec,
    input  logic       rti_dec,
    input  logic       hold,
    output logic       busy,
    output logic [1:0] seq_count,
    output logic       stall_if,
    output logic       flush_if_id,
    output logic       push,
    output logic       pop,
    output logic       stk_sel,
    output logic       pc_load,
    output logic [1:0] pc_src,
    output logic       flags_restore,
    output logic       int_ack
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_I_PC   = 3'd2,
        ST_I_FLG  = 3'd3,
        ST_I_VEC  = 3'd4,
        ST_R_POPF = 3'd5,
        ST_R_POPP = 3'd6,
        ST_R_LOAD = 3'd7
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

    state_t     state_r;
    state_t     next_state_s;
    logic [2:0] drain_cnt_r;
    logic [2:0] drain_cnt_nxt_s;
    logic       int_pending_r;
    logic       is_rti_r;
    logic       start_int_s;
    logic       start_rti_s;
    logic       start_ret_s;
    logic       strobe_en_s;

    // Side-effect strobes are suppressed while the pipeline is held.
    assign strobe_en_s = ~hold;

    // State, drain counter, pending-interrupt and RET/RTI flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            drain_cnt_r   <= 3'd0;
            int_pending_r <= 1'b0;
            is_rti_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            if (start_int_s) begin
                int_pending_r <= 1'b0;
            end else if (int_req) begin
                int_pending_r <= 1'b1;
            end else begin
                int_pending_r <= int_pending_r;
            end
            if (start_rti_s) begin
                is_rti_r <= 1'b1;
            end else if (start_ret_s) begin
                is_rti_r <= 1'b0;
            end else begin
                is_rti_r <= is_rti_r;
            end
        end
    end

    // Next-state selection; hold freezes every non-idle state in place.
    always_comb begin
        next_state_s    = state_r;
        drain_cnt_nxt_s = drain_cnt_r;
        start_int_s     = 1'b0;
        start_rti_s     = 1'b0;
        start_ret_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hold) begin
                    next_state_s = ST_IDLE;
                end else if (rti_dec) begin
                    start_rti_s  = 1'b1;
                    next_state_s = ST_R_POPF;
                end else if (ret_dec) begin
                    start_ret_s  = 1'b1;
                    next_state_s = ST_R_POPP;
                end else if (int_req || int_pending_r) begin
                    start_int_s = 1'b1;
                    if (DRAIN_INIT == 3'd0) begin
                        next_state_s = ST_I_PC;
                    end else begin
                        next_state_s    = ST_DRAIN;
                        drain_cnt_nxt_s = DRAIN_INIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (hold) begin
                    next_state_s = ST_DRAIN;
                end else if (drain_cnt_r <= 3'd1) begin
                    next_state_s    = ST_I_PC;
                    drain_cnt_nxt_s = 3'd0;
                end else begin
                    drain_cnt_nxt_s = drain_cnt_r - 3'd1;
                end
            end
            ST_I_PC:   next_state_s = hold ? ST_I_PC   : ST_I_FLG;
            ST_I_FLG:  next_state_s = hold ? ST_I_FLG  : ST_I_VEC;
            ST_I_VEC:  next_state_s = hold ? ST_I_VEC  : ST_IDLE;
            ST_R_POPF: next_state_s = hold ? ST_R_POPF : ST_R_POPP;
            ST_R_POPP: next_state_s = hold ? ST_R_POPP : ST_R_LOAD;
            ST_R_LOAD: next_state_s = hold ? ST_R_LOAD : ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register; only strobes see hold.
    always_comb begin
        busy          = 1'b0;
        seq_count     = 2'd0;
        stall_if      = 1'b0;
        flush_if_id   = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        stk_sel       = 1'b0;
        pc_load       = 1'b0;
        pc_src        = 2'b00;
        flags_restore = 1'b0;
        int_ack       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_DRAIN: begin
                busy     = 1'b1;
                stall_if = 1'b1;
            end
            ST_I_PC: begin
                busy      = 1'b1;
                stall_if  = 1'b1;
                seq_count = 2'd1;
                push      = strobe_en_s;
                stk_sel   = 1'b0;
            end
            ST_I_FLG: begin
                busy      = 1'b1;
                stall_if  = 1'b1;
                seq_count = 2'd2;
                push      = strobe_en_s;
                stk_sel   = 1'b1;
            end
            ST_I_VEC: begin
                busy        = 1'b1;
                stall_if    = 1'b1;
                seq_count   = 2'd3;
                pc_load     = strobe_en_s;
                pc_src      = 2'b01;
                flush_if_id = 1'b1;
                int_ack     = strobe_en_s;
            end
            ST_R_POPF: begin
                busy          = 1'b1;
                stall_if      = 1'b1;
                seq_count     = 2'd1;
                pop           = strobe_en_s;
                stk_sel       = 1'b1;
                flags_restore = strobe_en_s;
            end
            ST_R_POPP: begin
                busy      = 1'b1;
                stall_if  = 1'b1;
                seq_count = is_rti_r ? 2'd2 : 2'd1;
                pop       = strobe_en_s;
                stk_sel   = 1'b0;
            end
            ST_R_LOAD: begin
                busy        = 1'b1;
                stall_if    = 1'b1;
                seq_count   = is_rti_r ? 2'd3 : 2'd2;
                pc_load     = strobe_en_s;
                pc_src      = 2'b10;
                flush_if_id = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
